// File: rtl/lx_bus_requester_pkg.sv
// Shared definitions for the Lx bus requester: message encodings, log2 helper and FSM states.
package lx_bus_requester_pkg;

  localparam int unsigned NO_REQ    = 0;
  localparam int unsigned R_REQ     = 1;
  localparam int unsigned WB_REQ    = 2;
  localparam int unsigned MEM_SENT  = 6;
  localparam int unsigned MEM_READY = 7;

  // Ceiling log2; log2(1) == 0.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    RESP,
    WAIT_CLR
  } state_e;

endpackage

// File: rtl/lx_line_beat_mux.sv
// Line/beat steering: picks one bus-width slice out of a line and merges a beat into a line.
module lx_line_beat_mux
  import lx_bus_requester_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned CACHE_OFFSET_BITS = 2,
  parameter int unsigned BUS_OFFSET_BITS   = 1,
  localparam int unsigned CACHE_WIDTH = DATA_WIDTH << CACHE_OFFSET_BITS,
  localparam int unsigned BUS_WIDTH   = DATA_WIDTH << BUS_OFFSET_BITS,
  localparam int unsigned BEATS       = 1 << (CACHE_OFFSET_BITS - BUS_OFFSET_BITS),
  localparam int unsigned BEAT_BITS   = (BEATS > 1) ? log2(BEATS) : 1
) (
  input  logic [CACHE_WIDTH-1:0] line_in,
  input  logic [BEAT_BITS-1:0]   slice_sel,
  output logic [BUS_WIDTH-1:0]   slice_out,
  input  logic [CACHE_WIDTH-1:0] merge_line_in,
  input  logic [BEAT_BITS-1:0]   merge_sel,
  input  logic [BUS_WIDTH-1:0]   merge_data,
  output logic [CACHE_WIDTH-1:0] merged_line
);

  always_comb begin
    slice_out   = '0;
    merged_line = merge_line_in;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (slice_sel == BEAT_BITS'(i))
        slice_out = line_in[i*BUS_WIDTH +: BUS_WIDTH];
      if (merge_sel == BEAT_BITS'(i))
        merged_line[i*BUS_WIDTH +: BUS_WIDTH] = merge_data;
    end
  end

endmodule

// File: rtl/lx_bus_requester.sv
// Lx bus requester: turns full-line read/writeback requests into BEATS bus beats.
// Optional watchdog/retry enabled by defining LX_BUS_REQ_TIMEOUT_EN (adds TIMEOUT_CYCLES, timeout_error).
module lx_bus_requester
  import lx_bus_requester_pkg::*;
#(
  parameter int unsigned CACHE_OFFSET_BITS = 2,
  parameter int unsigned BUS_OFFSET_BITS   = 1,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned ADDRESS_BITS      = 32,
  parameter int unsigned MSG_BITS          = 4,
  parameter int unsigned MAX_OFFSET_BITS   = 3,
`ifdef LX_BUS_REQ_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES    = 64,
`endif
  localparam int unsigned CACHE_WIDTH = DATA_WIDTH << CACHE_OFFSET_BITS,
  localparam int unsigned BUS_WIDTH   = DATA_WIDTH << BUS_OFFSET_BITS,
  localparam int unsigned OFF_W       = log2(MAX_OFFSET_BITS) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MSG_BITS-1:0]     cache_msg_in,
  input  logic [ADDRESS_BITS-1:0] cache_address_in,
  input  logic [CACHE_WIDTH-1:0]  cache_data_in,
  output logic [MSG_BITS-1:0]     cache_msg_out,
  output logic [ADDRESS_BITS-1:0] cache_address_out,
  output logic [CACHE_WIDTH-1:0]  cache_data_out,
  output logic [MSG_BITS-1:0]     bus_msg_out,
  output logic [ADDRESS_BITS-1:0] bus_address_out,
  output logic [BUS_WIDTH-1:0]    bus_data_out,
  input  logic [MSG_BITS-1:0]     bus_msg_in,
  input  logic [ADDRESS_BITS-1:0] bus_address_in,
  input  logic [BUS_WIDTH-1:0]    bus_data_in,
  output logic [OFF_W-1:0]        req_offset,
  output logic                    req_ready,
  input  logic [OFF_W-1:0]        active_offset
`ifdef LX_BUS_REQ_TIMEOUT_EN
  ,
  output logic                    timeout_error
`endif
);

  localparam int unsigned BEATS     = 1 << (CACHE_OFFSET_BITS - BUS_OFFSET_BITS);
  localparam int unsigned BEAT_BITS = (BEATS > 1) ? log2(BEATS) : 1;
  localparam logic [BEAT_BITS-1:0]    LAST_BEAT = BEAT_BITS'(BEATS - 1);
  localparam logic [ADDRESS_BITS-1:0] BASE_MASK = ~ADDRESS_BITS'((1 << CACHE_OFFSET_BITS) - 1);

  state_e                  state_q;
  logic [BEAT_BITS-1:0]    beat_q, beat_nxt, slice_sel;
  logic [ADDRESS_BITS-1:0] base_q, base_in, beat_addr;
  logic [CACHE_WIDTH-1:0]  line_q, slice_src, merged_line;
  logic [BUS_WIDTH-1:0]    slice;
  logic                    offset_ok, read_hit, ack_hit, hold;

  function automatic logic [ADDRESS_BITS-1:0] addr_of(input logic [ADDRESS_BITS-1:0] base,
                                                      input logic [BEAT_BITS-1:0] b);
    return base | (ADDRESS_BITS'(b) << BUS_OFFSET_BITS);
  endfunction

  assign req_offset = OFF_W'(CACHE_OFFSET_BITS);

  // Outputs are registered, so the write slice is looked up for the beat being entered.
  always_comb begin
    base_in   = cache_address_in & BASE_MASK;
    beat_nxt  = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_BITS'(1);
    beat_addr = addr_of(base_q, beat_q);
    offset_ok = (active_offset == OFF_W'(CACHE_OFFSET_BITS));
    read_hit  = (state_q == READ) && !hold && offset_ok &&
                (bus_msg_in == MSG_BITS'(MEM_SENT)) && (bus_address_in == beat_addr);
    ack_hit   = (state_q == WRITE) && !hold && offset_ok &&
                (bus_msg_in == MSG_BITS'(MEM_READY)) && (bus_address_in == beat_addr);
    slice_src = (state_q == IDLE) ? cache_data_in : line_q;
    slice_sel = ((state_q == IDLE) || hold) ? '0 : beat_nxt;
  end

  lx_line_beat_mux #(
    .DATA_WIDTH       (DATA_WIDTH),
    .CACHE_OFFSET_BITS(CACHE_OFFSET_BITS),
    .BUS_OFFSET_BITS  (BUS_OFFSET_BITS)
  ) u_beat_mux (
    .line_in      (slice_src),
    .slice_sel    (slice_sel),
    .slice_out    (slice),
    .merge_line_in(line_q),
    .merge_sel    (beat_q),
    .merge_data   (bus_data_in),
    .merged_line  (merged_line)
  );

`ifdef LX_BUS_REQ_TIMEOUT_EN
  localparam int unsigned WD_BITS = log2(TIMEOUT_CYCLES) + 1;
  logic               retry_q;
  logic [WD_BITS-1:0] wd_q;
  assign hold = retry_q;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      beat_q            <= '0;
      base_q            <= '0;
      line_q            <= '0;
      cache_msg_out     <= '0;
      cache_address_out <= '0;
      cache_data_out    <= '0;
      bus_msg_out       <= '0;
      bus_address_out   <= '0;
      bus_data_out      <= '0;
      req_ready         <= 1'b0;
`ifdef LX_BUS_REQ_TIMEOUT_EN
      retry_q           <= 1'b0;
      wd_q              <= '0;
      timeout_error     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cache_msg_in == MSG_BITS'(R_REQ)) begin
            state_q         <= READ;
            base_q          <= base_in;
            line_q          <= '0;
            beat_q          <= '0;
            bus_msg_out     <= MSG_BITS'(R_REQ);
            bus_address_out <= base_in;
            req_ready       <= 1'b1;
          end else if (cache_msg_in == MSG_BITS'(WB_REQ)) begin
            state_q         <= WRITE;
            base_q          <= base_in;
            line_q          <= cache_data_in;
            beat_q          <= '0;
            bus_msg_out     <= MSG_BITS'(WB_REQ);
            bus_address_out <= base_in;
            bus_data_out    <= slice;
            req_ready       <= 1'b1;
          end
        end
        READ: begin
          if (read_hit) begin
            line_q <= merged_line;
            if (beat_q == LAST_BEAT) begin
              state_q           <= RESP;
              beat_q            <= '0;
              cache_msg_out     <= MSG_BITS'(MEM_SENT);
              cache_address_out <= base_q;
              cache_data_out    <= merged_line;
              bus_msg_out       <= MSG_BITS'(NO_REQ);
              bus_address_out   <= '0;
              req_ready         <= 1'b0;
            end else begin
              beat_q <= beat_nxt;
            end
          end
        end
        WRITE: begin
          if (ack_hit) begin
            if (beat_q == LAST_BEAT) begin
              state_q           <= RESP;
              beat_q            <= '0;
              cache_msg_out     <= MSG_BITS'(MEM_READY);
              cache_address_out <= base_q;
              cache_data_out    <= line_q;
              bus_msg_out       <= MSG_BITS'(NO_REQ);
              bus_address_out   <= '0;
              bus_data_out      <= '0;
              req_ready         <= 1'b0;
            end else begin
              beat_q          <= beat_nxt;
              bus_address_out <= addr_of(base_q, beat_nxt);
              bus_data_out    <= slice;
            end
          end
        end
        RESP: begin
          state_q       <= WAIT_CLR;
          cache_msg_out <= MSG_BITS'(NO_REQ);
        end
        WAIT_CLR: begin
          if (cache_msg_in == MSG_BITS'(NO_REQ))
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
`ifdef LX_BUS_REQ_TIMEOUT_EN
      // Placed after the case so a timeout or reissue overrides the bus outputs set above.
      timeout_error <= 1'b0;
      if (retry_q) begin
        retry_q         <= 1'b0;
        wd_q            <= '0;
        bus_msg_out     <= (state_q == READ) ? MSG_BITS'(R_REQ) : MSG_BITS'(WB_REQ);
        bus_address_out <= base_q;
        req_ready       <= 1'b1;
        if (state_q == WRITE)
          bus_data_out <= slice;
      end else if (((state_q == READ) || (state_q == WRITE)) && !(read_hit || ack_hit)) begin
        if (wd_q == WD_BITS'(TIMEOUT_CYCLES - 1)) begin
          timeout_error <= 1'b1;
          retry_q       <= 1'b1;
          wd_q          <= '0;
          beat_q        <= '0;
          bus_msg_out   <= MSG_BITS'(NO_REQ);
          req_ready     <= 1'b0;
        end else begin
          wd_q <= wd_q + WD_BITS'(1);
        end
      end else begin
        wd_q <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lx_bus_requester.sv
// Directed plus randomized bench for lx_bus_requester at default parameters (BEATS=2, 64-bit beats).
module tb_lx_bus_requester;

  localparam logic [3:0] M_NO  = 4'd0;
  localparam logic [3:0] M_RD  = 4'd1;
  localparam logic [3:0] M_WB  = 4'd2;
  localparam logic [3:0] M_SNT = 4'd6;
  localparam logic [3:0] M_RDY = 4'd7;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   cache_msg_in = '0;
  logic [31:0]  cache_address_in = '0;
  logic [127:0] cache_data_in = '0;
  logic [3:0]   cache_msg_out;
  logic [31:0]  cache_address_out;
  logic [127:0] cache_data_out;
  logic [3:0]   bus_msg_out;
  logic [31:0]  bus_address_out;
  logic [63:0]  bus_data_out;
  logic [3:0]   bus_msg_in = '0;
  logic [31:0]  bus_address_in = '0;
  logic [63:0]  bus_data_in = '0;
  logic [2:0]   req_offset;
  logic         req_ready;
  logic [2:0]   active_offset = 3'd2;
`ifdef LX_BUS_REQ_TIMEOUT_EN
  logic         timeout_error;
`endif

  int errors = 0;
  int checks = 0;

  lx_bus_requester dut (
    .clock            (clock),
    .reset            (reset),
    .cache_msg_in     (cache_msg_in),
    .cache_address_in (cache_address_in),
    .cache_data_in    (cache_data_in),
    .cache_msg_out    (cache_msg_out),
    .cache_address_out(cache_address_out),
    .cache_data_out   (cache_data_out),
    .bus_msg_out      (bus_msg_out),
    .bus_address_out  (bus_address_out),
    .bus_data_out     (bus_data_out),
    .bus_msg_in       (bus_msg_in),
    .bus_address_in   (bus_address_in),
    .bus_data_in      (bus_data_in),
    .req_offset       (req_offset),
    .req_ready        (req_ready),
    .active_offset    (active_offset)
`ifdef LX_BUS_REQ_TIMEOUT_EN
    ,
    .timeout_error    (timeout_error)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus_msg_in     = M_NO;
    bus_address_in = '0;
    bus_data_in    = '0;
    active_offset  = 3'd2;
  endtask

  // A beat the requester must ignore: wrong beat address, foreign offset or wrong message.
  task automatic drive_noise(input logic [31:0] good_addr, input logic [31:0] other_addr,
                             input logic [3:0] good_msg);
    logic [2:0] off;
    bus_msg_in     = good_msg;
    bus_address_in = good_addr;
    active_offset  = 3'd2;
    bus_data_in    = {$urandom, $urandom};
    case ($urandom_range(3))
      0: bus_address_in = other_addr;
      1: bus_address_in = good_addr + 32'h8;
      2: begin
        off = 3'($urandom_range(7));
        if (off == 3'd2) off = 3'd1;
        active_offset = off;
      end
      default: bus_msg_in = (good_msg == M_SNT) ? M_RDY : M_SNT;
    endcase
  endtask

  task automatic do_read(input logic [31:0] addr, input int gap, input int noise,
                         input bit hold, output int lat);
    logic [31:0]  base;
    logic [63:0]  beat_d [2];
    logic [127:0] exp_line;
    base = addr & ~32'h3;
    lat  = 0;
    cache_msg_in     = M_RD;
    cache_address_in = addr;
    tick(); lat++;
    check("rd_bus_msg", bus_msg_out, M_RD);
    check("rd_bus_addr", bus_address_out, base);
    check("rd_req_ready", req_ready, 1);
    if (!hold) cache_msg_in = M_NO;
    repeat (gap) begin tick(); lat++; end
    for (int b = 0; b < 2; b++) begin
      beat_d[b] = {$urandom, $urandom};
      repeat (noise) begin
        drive_noise(base + 32'(2 * b), base + 32'(2 * (1 - b)), M_SNT);
        tick(); lat++;
        check("rd_noise_bus_msg", bus_msg_out, M_RD);
        check("rd_noise_cache_msg", cache_msg_out, M_NO);
      end
      bus_msg_in     = M_SNT;
      bus_address_in = base + 32'(2 * b);
      bus_data_in    = beat_d[b];
      active_offset  = 3'd2;
      tick(); lat++;
      bus_idle();
    end
    exp_line = {beat_d[1], beat_d[0]};
    check("rd_done_msg", cache_msg_out, M_SNT);
    check("rd_done_addr", cache_address_out, base);
    check("rd_done_line", cache_data_out, exp_line);
    check("rd_done_bus_msg", bus_msg_out, M_NO);
    check("rd_done_req_ready", req_ready, 0);
    tick();
    check("rd_pulse_end", cache_msg_out, M_NO);
    if (hold) begin
      repeat (3) begin
        tick();
        check("rd_hold_bus_msg", bus_msg_out, M_NO);
        check("rd_hold_req_ready", req_ready, 0);
      end
      cache_msg_in = M_NO;
    end
    tick();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [127:0] line, input int noise);
    logic [31:0] base;
    base = addr & ~32'h3;
    cache_msg_in     = M_WB;
    cache_address_in = addr;
    cache_data_in    = line;
    tick();
    cache_msg_in  = M_NO;
    cache_data_in = {$urandom, $urandom, $urandom, $urandom};
    for (int b = 0; b < 2; b++) begin
      check("wr_bus_msg", bus_msg_out, M_WB);
      check("wr_bus_addr", bus_address_out, base + 32'(2 * b));
      check("wr_bus_data", bus_data_out, line[64*b +: 64]);
      repeat (noise) begin
        drive_noise(base + 32'(2 * b), base + 32'(2 * (1 - b)), M_RDY);
        tick();
        check("wr_noise_addr", bus_address_out, base + 32'(2 * b));
        check("wr_noise_data", bus_data_out, line[64*b +: 64]);
      end
      bus_msg_in     = M_RDY;
      bus_address_in = base + 32'(2 * b);
      active_offset  = 3'd2;
      tick();
      bus_idle();
    end
    check("wr_done_msg", cache_msg_out, M_RDY);
    check("wr_done_addr", cache_address_out, base);
    check("wr_done_line", cache_data_out, line);
    check("wr_done_bus_msg", bus_msg_out, M_NO);
    check("wr_done_req_ready", req_ready, 0);
    tick();
    check("wr_pulse_end", cache_msg_out, M_NO);
    tick();
  endtask

  initial begin
    int lat;
    logic [127:0] line;
    logic [31:0]  addr;

    bus_idle();
    repeat (3) tick();
    check("rst_cache_msg", cache_msg_out, M_NO);
    check("rst_bus_msg", bus_msg_out, M_NO);
    check("rst_bus_addr", bus_address_out, 0);
    check("rst_cache_addr", cache_address_out, 0);
    check("rst_cache_data", cache_data_out, 0);
    check("rst_req_ready", req_ready, 0);
    check("req_offset", req_offset, 2);
    reset = 1'b1;
    tick();

    cache_msg_in = M_SNT;
    tick();
    check("idle_ignore_msg", bus_msg_out, M_NO);
    check("idle_ignore_ready", req_ready, 0);
    cache_msg_in = M_NO;
    tick();

    do_read(32'h105, 1, 0, 1'b0, lat);
    check("rd_latency", lat, 4);

    line = {$urandom, $urandom, $urandom, $urandom};
    do_write(32'h200, line, 2);

    do_read(32'h104, 0, 3, 1'b0, lat);
    do_read(32'h40A, 1, 1, 1'b1, lat);

    // Reset with one beat already taken, asserted between clock edges.
    cache_msg_in     = M_RD;
    cache_address_in = 32'h300;
    tick();
    cache_msg_in   = M_NO;
    bus_msg_in     = M_SNT;
    bus_address_in = 32'h300;
    bus_data_in    = {$urandom, $urandom};
    tick();
    bus_idle();
    #2 reset = 1'b0;
    #1;
    check("mid_rst_bus_msg", bus_msg_out, M_NO);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_cache_msg", cache_msg_out, M_NO);
    #1 reset = 1'b1;
    tick();
    do_read(32'h301, 0, 0, 1'b0, lat);

    for (int n = 0; n < 24; n++) begin
      addr = $urandom;
      if ($urandom_range(1) == 0) begin
        do_read(addr, int'($urandom_range(2)), int'($urandom_range(2)), 1'b0, lat);
      end else begin
        line = {$urandom, $urandom, $urandom, $urandom};
        do_write(addr, line, int'($urandom_range(2)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lx_bus_requester.md
Name: lx_bus_requester

Overview:
- Upstream-side initiator for the Lx line bus: takes a full-line read or writeback request from an upper-level cache controller and drives it onto the bus as BUS_WIDTH beats.
- Reads: collects returned beats into a line. Writebacks: sends beats and waits for a per-beat acknowledge.
- Sits between an L(x-1) cache controller and the bus interface of the Lx cache. It is the requester end of the msg/address/data bus with req_offset/req_ready/active_offset.

Parameters:
- CACHE_OFFSET_BITS, 2: log2 words per line on the upstream side.
- BUS_OFFSET_BITS, 1: log2 words per bus beat. Must be <= CACHE_OFFSET_BITS.
- DATA_WIDTH, 32: word width.
- ADDRESS_BITS, 32: word address width.
- MSG_BITS, 4: message width.
- MAX_OFFSET_BITS, 3: largest line offset any bus agent uses.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cache_msg_in  in  MSG_BITS  upstream request: NO_REQ, R_REQ or WB_REQ
- cache_address_in  in  ADDRESS_BITS  request word address
- cache_data_in  in  CACHE_WIDTH  writeback line
- cache_msg_out  out  MSG_BITS  MEM_SENT (read done), MEM_READY (writeback done), else NO_REQ
- cache_address_out  out  ADDRESS_BITS  line base of the completed request
- cache_data_out  out  CACHE_WIDTH  assembled read line
- bus_msg_out  out  MSG_BITS  R_REQ, WB_REQ or NO_REQ
- bus_address_out  out  ADDRESS_BITS  bus address
- bus_data_out  out  BUS_WIDTH  writeback beat
- bus_msg_in  in  MSG_BITS  responder message: MEM_SENT or MEM_READY
- bus_address_in  in  ADDRESS_BITS  responder beat address
- bus_data_in  in  BUS_WIDTH  read beat
- req_offset  out  log2(MAX_OFFSET_BITS)+1  constant CACHE_OFFSET_BITS
- req_ready  out  1  high while a bus transaction is outstanding
- active_offset  in  log2(MAX_OFFSET_BITS)+1  offset the responder is currently serving

Behaviour:
- Derived widths:
  - CACHE_WIDTH = DATA_WIDTH << CACHE_OFFSET_BITS
  - BUS_WIDTH = DATA_WIDTH << BUS_OFFSET_BITS
  - BEATS = 1 << (CACHE_OFFSET_BITS - BUS_OFFSET_BITS)
  - base = cache_address_in with its low CACHE_OFFSET_BITS cleared, latched on accept
  - beat address = base | (beat << BUS_OFFSET_BITS)
- Reset (async, low): state IDLE, beat counter 0, all msg outputs NO_REQ, addresses and data 0, req_ready 0. Asserting reset mid-transaction drops the bus request in the same cycle with no completion message.
- State IDLE:
  - R_REQ: latch base, clear line buffer, go to READ.
  - WB_REQ: latch base and line, go to WRITE.
  - Any other message is ignored.
  - The transition is registered, so the bus request appears one cycle after the cache request.
- State READ:
  - Drive bus_msg_out=R_REQ, bus_address_out=base, req_ready=1.
  - A beat is accepted when bus_msg_in==MEM_SENT, bus_address_in==current beat address and active_offset==CACHE_OFFSET_BITS. On accept, bus_data_in is written to line slice [beat] and the counter increments.
  - Non-matching beats are ignored.
  - On accepting the last beat, go to RESP.
- State WRITE:
  - Drive WB_REQ, the current beat address, line slice [beat], req_ready=1.
  - Advance on bus_msg_in==MEM_READY with matching address and active_offset.
  - On the last acknowledge, go to RESP.
- State RESP: exactly one cycle. cache_msg_out=MEM_SENT (read) or MEM_READY (write), cache_address_out=base, cache_data_out=line. bus_msg_out=NO_REQ, req_ready=0.
- State WAIT_CLR: hold outputs at NO_REQ until cache_msg_in==NO_REQ, then go to IDLE. This prevents a held request from being reissued.
- Counter wraps to 0 on entering RESP.
- BEATS==1: a single accept completes the transaction.
- With a responder supplying one beat per cycle, read latency from cache request to MEM_SENT is BEATS+2 cycles.
- Requests arriving outside IDLE are ignored.

Optional Feature:
- Macro LX_BUS_REQ_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT_CYCLES (default 64) and output timeout_error (1 bit).
  - A watchdog counts consecutive READ/WRITE cycles without an accepted beat or acknowledge.
  - On reaching TIMEOUT_CYCLES: pulse timeout_error for 1 cycle, reset the beat counter to 0, drive NO_REQ for one cycle, then reissue the transaction from beat 0.
  - The watchdog clears on every accept.
- When undefined: the block waits indefinitely and the port and logic are absent.

Decomposition:
- Shared package holds:
  - message encodings: NO_REQ=0, R_REQ=1, WB_REQ=2, MEM_SENT=6, MEM_READY=7
  - the log2 function
  - the state enumeration
- One natural sub-module, lx_line_beat_mux: selects the write slice and merges read beats into the line buffer by beat index.

Test Plan:
All scenarios use defaults, so BEATS=2 and BUS_WIDTH=64.
- R_REQ at address 0x105 -> bus R_REQ at 0x104. Responder returns MEM_SENT 0x104/data A, then 0x106/data B -> cache_msg_out=MEM_SENT for one cycle, address 0x104, line {B,A}, 4 cycles after the request.
- WB_REQ at 0x200, line {D,C} -> bus WB_REQ 0x200/C, held until MEM_READY 0x200; then 0x202/D; then cache MEM_READY.
- During READ, beats with the wrong address (0x108) or active_offset=1 -> ignored, counter unchanged.
- Cache keeps R_REQ asserted after MEM_SENT -> no second bus request until cache_msg_in returns to NO_REQ.
- Reset asserted with one read beat already accepted -> bus_msg_out=NO_REQ immediately. After release, a new R_REQ restarts at beat 0.
- LX_BUS_REQ_TIMEOUT_EN with TIMEOUT_CYCLES=8 and a silent responder -> timeout_error pulses at cycle 8, R_REQ is reissued after one NO_REQ cycle.
